// File: rtl/seq_detect_prog.sv
// seq_detect_prog: run-time programmable serial sequence detector with
// selectable overlap policy, Mealy/Moore output and a saturating match counter.
module seq_detect_prog #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 8,
  parameter bit MOORE = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic cfg_load,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0] pat_len,
  input  logic overlap,
  input  logic en,
  input  logic din,
  output logic dout,
  output logic [LEN_W-1:0] progress,
  output logic [CNT_W-1:0] match_count,
  output logic err_cfg
);
  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);
  logic [MAX_LEN-1:0] pat_q, pat_d, cand, mask;
  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic [LEN_W-1:0] len_q, len_d, fill_q, fill_d, fill_n;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic ovl_q, ovl_d, dout_q, dout_d, err_q, err_d, hit, restart;
  genvar i;
  for (i = 0; i < MAX_LEN; i++) begin : g_mask
    assign mask[i] = len_q > LEN_W'(i);
  end
  // fill never exceeds len, so saturation is a simple equality test
  always_comb begin
    cand = {hist_q, din};
    fill_n = (fill_q == len_q) ? len_q : fill_q + LEN_W'(1);
    hit = en && len_q != '0 && fill_n == len_q && ((cand ^ pat_q) & mask) == '0;
    restart = hit && !ovl_q;
    pat_d = cfg_load ? pattern : pat_q;
    len_d = cfg_load ? ((pat_len > MAX_L) ? MAX_L : pat_len) : len_q;
    ovl_d = cfg_load ? overlap : ovl_q;
    err_d = cfg_load ? (pat_len == '0 || pat_len > MAX_L) : err_q;
    hist_d = (cfg_load || restart) ? '0 : en ? cand[MAX_LEN-2:0] : hist_q;
    fill_d = (cfg_load || restart) ? '0 : en ? fill_n : fill_q;
    cnt_d = cfg_load ? '0 : (hit && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
    dout_d = !cfg_load && hit;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q <= '0;
      len_q <= '0;
      ovl_q <= 1'b0;
      err_q <= 1'b0;
      hist_q <= '0;
      fill_q <= '0;
      cnt_q <= '0;
      dout_q <= 1'b0;
    end else begin
      pat_q <= pat_d;
      len_q <= len_d;
      ovl_q <= ovl_d;
      err_q <= err_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      cnt_q <= cnt_d;
      dout_q <= dout_d;
    end
  end
  assign dout = MOORE ? dout_q : hit;
  assign progress = fill_q;
  assign match_count = cnt_q;
  assign err_cfg = err_q;
endmodule

// File: tb/tb_seq_detect_prog.sv
// tb_seq_detect_prog: scoreboard bench driving a Mealy, a Moore and a 2-bit-counter
// detector with a shared stimulus stream and checking each against expected results.
module tb_seq_detect_prog;
  logic clk = 1'b0, reset = 1'b1, cfg_load = 1'b0, overlap = 1'b0, en = 1'b0, din = 1'b0;
  logic [7:0] pattern = '0;
  logic [3:0] pat_len = '0;
  logic d0, d1, d2, e0, e1, e2;
  logic [3:0] p0, p1, p2;
  logic [7:0] c0, c1;
  logic [1:0] c2;
  int n_chk = 0, n_fail = 0;
  typedef struct {
    string tag;
    logic d;
    logic [3:0] p;
    int c;
  } exp_t;
  exp_t sb[$];

  seq_detect_prog #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8), .MOORE(1'b0)) u_mealy (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .pattern(pattern), .pat_len(pat_len),
    .overlap(overlap), .en(en), .din(din), .dout(d0), .progress(p0), .match_count(c0), .err_cfg(e0));
  seq_detect_prog #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8), .MOORE(1'b1)) u_moore (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .pattern(pattern), .pat_len(pat_len),
    .overlap(overlap), .en(en), .din(din), .dout(d1), .progress(p1), .match_count(c1), .err_cfg(e1));
  seq_detect_prog #(.MAX_LEN(8), .LEN_W(4), .CNT_W(2), .MOORE(1'b0)) u_sat (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .pattern(pattern), .pat_len(pat_len),
    .overlap(overlap), .en(en), .din(din), .dout(d2), .progress(p2), .match_count(c2), .err_cfg(e2));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic e, input logic d, input logic ed, input logic [3:0] ep,
                       input int ec, input string tag);
    @(negedge clk);
    en = e;
    din = d;
    sb.push_back('{tag, ed, ep, ec});
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    cfg_load = 1'b0;
    en = 1'b1;
    din = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    en = 1'b0;
    check({tag, "_prog"}, p0, 0);
    check({tag, "_cnt"}, c0, 0);
    check({tag, "_err"}, e0, 0);
    check({tag, "_moore"}, d1, 0);
  endtask

  task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                      input logic exp_err, input string tag);
    @(negedge clk);
    cfg_load = 1'b1;
    pattern = pat;
    pat_len = len;
    overlap = ovl;
    en = 1'b1;
    din = 1'b1;
    @(posedge clk);
    #1;
    cfg_load = 1'b0;
    en = 1'b0;
    check({tag, "_err"}, e0, 32'(exp_err));
    check({tag, "_prog"}, p0, 0);
    check({tag, "_cnt"}, c0, 0);
    check({tag, "_moore"}, d1, 0);
  endtask

  // Mealy dout is taken mid-cycle with inputs settled; state-derived outputs after the edge
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() != 0) begin
        x = sb.pop_front();
        check({x.tag, "_mealy"}, d0, 32'(x.d));
        @(posedge clk);
        #1;
        check({x.tag, "_moore"}, d1, 32'(x.d));
        check({x.tag, "_prog"}, p0, 32'(x.p));
        check({x.tag, "_cnt"}, c0, x.c);
        check({x.tag, "_sat"}, c2, (x.c > 3) ? 3 : x.c);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [9:0] s1 = 10'b1011110111;
    logic [9:0] m_ov = 10'b0000110001;
    logic [9:0] m_no = 10'b0000100001;
    logic [3:0] pr_ov[10] = '{1, 2, 3, 3, 3, 3, 3, 3, 3, 3};
    logic [3:0] pr_no[10] = '{1, 2, 3, 3, 0, 1, 2, 3, 3, 0};
    int c_ov[10] = '{0, 0, 0, 0, 1, 2, 2, 2, 2, 3};
    int c_no[10] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 2};
    logic [7:0] a5 = 8'hA5;
    do_reset("rst0");
    load(8'h07, 4'd3, 1'b0, 1'b0, "ld_mid");
    drive(1'b1, 1'b1, 1'b0, 4'd1, 0, "mid1");
    drive(1'b1, 1'b1, 1'b0, 4'd2, 0, "mid2");
    do_reset("rst_mid");
    for (int k = 0; k < 3; k++) drive(1'b1, 1'b1, 1'b0, 4'd0, 0, "dis");
    load(8'h07, 4'd3, 1'b1, 1'b0, "ld_ov");
    for (int k = 0; k < 10; k++)
      drive(1'b1, s1[9-k], m_ov[9-k], pr_ov[k], c_ov[k], $sformatf("ov%0d", k + 1));
    load(8'h07, 4'd3, 1'b0, 1'b0, "ld_no");
    for (int k = 0; k < 10; k++)
      drive(1'b1, s1[9-k], m_no[9-k], pr_no[k], c_no[k], $sformatf("no%0d", k + 1));
    load(8'h05, 4'd3, 1'b0, 1'b0, "ld_gap");
    drive(1'b1, 1'b1, 1'b0, 4'd1, 0, "gap_b1");
    drive(1'b0, 1'b0, 1'b0, 4'd1, 0, "gap_idle1");
    drive(1'b0, 1'b1, 1'b0, 4'd1, 0, "gap_idle2");
    drive(1'b1, 1'b0, 1'b0, 4'd2, 0, "gap_b2");
    drive(1'b1, 1'b1, 1'b1, 4'd0, 1, "gap_b3");
    drive(1'b0, 1'b1, 1'b0, 4'd0, 1, "gap_fall");
    load(8'hFF, 4'd0, 1'b1, 1'b1, "ld_len0");
    for (int k = 0; k < 4; k++) drive(1'b1, 1'b1, 1'b0, 4'd0, 0, "len0");
    load(8'hA5, 4'd12, 1'b0, 1'b1, "ld_len12");
    for (int k = 0; k < 8; k++)
      drive(1'b1, a5[7-k], k == 7, (k == 7) ? 4'd0 : 4'(k + 1), (k == 7) ? 1 : 0,
            $sformatf("a5_%0d", k));
    load(8'hF1, 4'd1, 1'b1, 1'b0, "ld_sat");
    for (int k = 0; k < 5; k++) drive(1'b1, 1'b1, 1'b1, 4'd1, k + 1, $sformatf("sat%0d", k + 1));
    drive(1'b1, 1'b0, 1'b0, 4'd1, 5, "sat_zero");
    repeat (3) @(posedge clk);
    #2;
    if (sb.size() != 0) check("sb_drain", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/seq_detect_prog.md
Name: seq_detect_prog

Overview:
Programmable serial sequence detector. It is the parametrised successor of the fixed-pattern Mealy detectors in the sequence-detector set. Pattern, pattern length and overlap policy are loaded at run time. Output timing (Mealy or Moore) is chosen by parameter. The block also reports how many bits of the current match are in progress and keeps a saturating count of matches.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (2..16)
LEN_W, 4, width of pat_len/progress; must satisfy 2^LEN_W > MAX_LEN
CNT_W, 8, width of match counter
MOORE, 0, 0 = Mealy (combinational dout), 1 = Moore (registered dout)

Ports:
clk  input  1  system clock, all state changes on rising edge
reset  input  1  synchronous, active-high reset
cfg_load  input  1  pulse: capture pattern/pat_len/overlap, clear history
pattern  input  MAX_LEN  pattern bits; pattern[pat_len-1] is received first, pattern[0] last
pat_len  input  LEN_W  pattern length in bits
overlap  input  1  1 = overlapping matches allowed, 0 = restart after a match
en  input  1  din is valid this cycle
din  input  1  serial data bit
dout  output  1  match indication
progress  output  LEN_W  valid bits accumulated toward a match, saturates at active length
match_count  output  CNT_W  number of matches since reset/cfg_load, saturating
err_cfg  output  1  loaded pat_len was 0 or greater than MAX_LEN

Behaviour:
- Reset (reset=1 at an edge):
  - hist=0, fill=0, match_count=0, registered dout=0, err_cfg=0.
  - Config registers: pattern=0, len=0, overlap=0. The block is disabled until the first cfg_load.
  - reset has priority over cfg_load and en.
- cfg_load=1 at an edge (no reset):
  - Registers pattern, pat_len and overlap; clears hist, fill, match_count and registered dout.
  - Any en/din in that cycle is ignored.
  - If pat_len==0, active len=0 (detection disabled, err_cfg=1).
  - If pat_len>MAX_LEN, active len=MAX_LEN (err_cfg=1).
  - Otherwise active len=pat_len and err_cfg=0.
- Candidate window: cand = {hist[MAX_LEN-2:0], din}; fill_n = min(fill+1, len).
- hit = en & (len!=0) & (fill_n==len) & ((cand ^ pattern_reg) & mask)==0, where mask = low len bits set.
- On an edge with en=1 (no reset, no cfg_load):
  - hist <= cand.
  - If hit & !overlap: fill <= 0 and hist <= 0, so the next match needs a full fresh pattern.
  - Otherwise fill <= fill_n.
  - If hit and match_count != all-ones: match_count <= match_count+1.
- en=0: all state holds; hit=0.
- Mealy (MOORE=0): dout = hit, combinational, in the same cycle the completing bit is presented. It depends on the current en/din.
- Moore (MOORE=1): dout <= hit at the edge. dout is high for exactly one cycle after the edge that sampled the completing bit, and 0 after reset or cfg_load.
- progress = fill (registered value). Non-overlap match returns it to 0. Overlap keeps it at len.
- match_count saturates at 2^CNT_W-1 and never wraps.
- Back-to-back matches in overlap mode assert dout on consecutive valid bits. With gaps in en, Moore dout falls after one cycle regardless.

Test Plan:
- Reset mid-stream: load 3'b111/len 3, feed 1,1, then assert reset -> dout=0, progress=0, match_count=0, detection disabled (len=0). Feed 1,1,1 -> no match.
- Overlap on: load pattern 111, len 3, overlap=1; feed 1,0,1,1,1,1,0,1,1,1 with en=1 -> Mealy dout high on bits 5, 6 and 10. match_count=3.
- Overlap off: same stream with overlap=0 -> dout on bits 5 and 10 only. match_count=2; progress=0 after bit 5.
- Moore and en gaps: MOORE=1, pattern 101, len 3; feed 1, en=0 for 2 cycles, 0, 1 -> dout rises for exactly one cycle after the edge sampling the final 1. Gap cycles do not break the match.
- Config errors: cfg_load with pat_len=0 -> err_cfg=1, no matches on any stream. cfg_load with pat_len=12 (MAX_LEN=8) -> err_cfg=1, acts as len 8. 8-bit pattern 8'hA5 streamed MSB-first -> one match.
- Saturation: CNT_W=2, pattern 1, len 1, overlap=1; feed five 1s -> match_count goes 1, 2, 3, 3, 3. dout stays high on every bit.
